io_mem_arbiter: RTL and testbench
=================================

IO_MEM_ARBITER -- requirements
Module: io_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a granted transaction may wait for s_ready (range 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_valid, m1_valid  input  1 each  master 0/1 request (PicoRV32 native memory handshake).
REQ-005 m0_addr, m1_addr  input  32 each  master 0/1 byte address.
REQ-006 m0_wdata, m1_wdata  input  32 each  master 0/1 write data.
REQ-007 m0_wstrb, m1_wstrb  input  4 each  master 0/1 byte strobes; 0 means read.
REQ-008 m0_ready, m1_ready  output  1 each  completion pulse to master 0/1.
REQ-009 m0_rdata, m1_rdata  output  32 each  read data to master 0/1.
REQ-010 s_valid  output  1  request to shared slave (io_memory port).
REQ-011 s_addr, s_wdata  output  32 each  forwarded address/data of owning master.
REQ-012 s_wstrb  output  4  forwarded strobes of owning master.
REQ-013 s_ready  input  1  slave completion.
REQ-014 s_rdata  input  32  slave read data.
REQ-015 err  output  1  one-cycle pulse on timeout abort.
REQ-016 owner  output  1  index of current/last granted master.

Function
REQ-017 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-018 IDLE: one valid master -> grant it; both valid -> grant master != prio; none -> stay IDLE.
REQ-019 Grant registers owner and enters BUSY on the next edge; cycle of request sampling = N, s_valid first high in N+1.
REQ-020 BUSY: s_valid = valid of owner; s_addr/s_wdata/s_wstrb = owner's signals, combinationally muxed.
REQ-021 Outside BUSY: s_valid=0, s_addr/s_wdata/s_wstrb = 0.
REQ-022 BUSY with s_ready=1: owner's m*_ready=1 same cycle (combinational), m*_rdata=s_rdata; next state DONE; prio <= owner.
REQ-023 Non-owner m*_ready is always 0; non-owner m*_rdata = 0.
REQ-024 DONE lasts exactly one cycle, drives s_valid=0, then IDLE (covers master's valid-drop cycle, prevents re-issue).
REQ-025 Timeout counter: cleared on entry to BUSY, increments each BUSY cycle without s_ready.
REQ-026 Counter reaching TIMEOUT-1 without s_ready: owner m*_ready=1, m*_rdata=32'hDEAD_BEEF, err=1 that cycle; next DONE; prio <= owner.
REQ-027 s_ready and timeout in same cycle: s_ready wins, err=0, rdata=s_rdata.
REQ-028 Owner drops valid in BUSY before s_ready: abort, no m*_ready, no err, next IDLE, prio unchanged.
REQ-029 s_ready outside BUSY is ignored; no m*_ready generated.
REQ-030 A new request arriving in DONE is not granted before the following IDLE cycle.
REQ-031 Fairness: back-to-back requests from both masters alternate grants; no master waits more than one transaction.

Reset
REQ-032 reset=1 forces state IDLE, owner=0, prio=1 (master 0 wins first tie), timeout counter 0, err=0, m*_ready=0, s_valid=0, asynchronously.
REQ-033 Reset mid-BUSY: in-flight transaction dropped, no m*_ready or err pulse after reset release.
REQ-034 First grant is possible in the first cycle after reset deasserts.

Verification
V-1 m0 write addr=OUT32BIT, wdata=32'h1234_5678, wstrb=4'hF at N; slave ready at N+2 -> s_valid N+1..N+2, m0_ready=1 at N+2, s_wdata=32'h1234_5678, owner=0, state IDLE at N+4.
V-2 m0 and m1 both valid from reset release, continuously re-requesting -> grant order 0,1,0,1; each m*_ready exactly once per transaction.
V-3 m1 read, slave never ready, TIMEOUT=16 -> m1_ready=1 with m1_rdata=32'hDEAD_BEEF and err=1 on 16th BUSY cycle; s_valid low next cycle.
V-4 s_ready asserted on the same cycle the counter hits TIMEOUT-1 -> err=0, m*_rdata=s_rdata.
V-5 reset pulsed while BUSY with m0 -> s_valid=0 immediately; after release m0_ready never pulses for old request; pending m1 granted first.
V-6 m0 drops valid after 3 BUSY cycles -> no m0_ready, no err, IDLE next; subsequent tie still grants master 1 per unchanged prio.

Source files
------------

// File: rtl/io_mem_arbiter_if.sv
// Bundle of every handshake/bus signal around io_mem_arbiter.
//   m0_*/m1_*   : PicoRV32-style native memory ports of the two CPU masters
//   s_*         : request port toward the single shared io_memory slave
//   err, owner  : timeout-abort pulse and index of current/last granted master
// Modports:
//   slave  : arbiter view (it serves the two masters and drives the slave port)
//   master : environment view (the two masters plus the shared slave)
interface io_mem_arbiter_if;
    logic        m0_valid;
    logic        m1_valid;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [3:0]  m0_wstrb;
    logic [3:0]  m1_wstrb;
    logic        m0_ready;
    logic        m1_ready;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        err;
    logic        owner;

    modport slave (
        input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wstrb, m1_wstrb, s_ready, s_rdata,
        output m0_ready, m1_ready, m0_rdata, m1_rdata, s_valid, s_addr,
               s_wdata, s_wstrb, err, owner
    );

    modport master (
        output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wstrb, m1_wstrb, s_ready, s_rdata,
        input  m0_ready, m1_ready, m0_rdata, m1_rdata, s_valid, s_addr,
               s_wdata, s_wstrb, err, owner
    );
endinterface

// File: rtl/io_mem_arbiter.sv
// Two-master arbiter in front of one shared io_memory port.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : io_mem_arbiter_if.slave (master requests, slave port, err, owner)
// Parameter TIMEOUT (2..255): BUSY cycles a grant may wait for s_ready.
//
// state | meaning
// IDLE  | sample requests, grant one master (tie -> master != prio)
// BUSY  | owner's request forwarded to slave, waiting for s_ready/timeout
// DONE  | one quiet cycle while the master drops valid; no re-grant
module io_mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            reset,
    io_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0]  CNT_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       prio_q, prio_d;
    logic [7:0] cnt_q, cnt_d;

    logic       own_valid;
    logic       busy;
    logic       hit;
    logic       expire;
    logic       finish;
    logic [31:0] rdata_sel;

    // Completion terms shared by next-state and output logic. s_ready beats
    // an expiring counter in the same cycle.
    always_comb begin
        own_valid = owner_q ? bus.m1_valid : bus.m0_valid;
        busy      = (state_q == BUSY);
        hit       = busy && own_valid && bus.s_ready;
        expire    = busy && own_valid && !bus.s_ready && (cnt_q == CNT_LAST);
        finish    = hit || expire;
        rdata_sel = expire ? ABORT_DATA : bus.s_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    state_d = BUSY;
                    cnt_d   = 8'd0;
                    if (bus.m0_valid && bus.m1_valid) owner_d = ~prio_q;
                    else                              owner_d = bus.m1_valid;
                end
            end
            BUSY: begin
                // A master withdrawing its request aborts silently; prio is
                // left alone so the withdrawn master keeps its turn.
                if (!own_valid) begin
                    state_d = IDLE;
                end else if (finish) begin
                    state_d = DONE;
                    prio_d  = owner_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_valid  = 1'b0;
        bus.s_addr   = 32'd0;
        bus.s_wdata  = 32'd0;
        bus.s_wstrb  = 4'd0;
        bus.m0_ready = 1'b0;
        bus.m1_ready = 1'b0;
        bus.m0_rdata = 32'd0;
        bus.m1_rdata = 32'd0;
        bus.err      = expire;
        bus.owner    = owner_q;
        if (busy) begin
            bus.s_valid = own_valid;
            bus.s_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
            bus.s_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;
            bus.s_wstrb = owner_q ? bus.m1_wstrb : bus.m0_wstrb;
        end
        if (finish) begin
            if (owner_q) begin
                bus.m1_ready = 1'b1;
                bus.m1_rdata = rdata_sel;
            end else begin
                bus.m0_ready = 1'b1;
                bus.m0_rdata = rdata_sel;
            end
        end
    end
endmodule

// File: tb/tb_io_mem_arbiter.sv
module tb_io_mem_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    io_mem_arbiter_if bus ();

    io_mem_arbiter #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
        bus.m0_addr  = 32'd0; bus.m1_addr  = 32'd0;
        bus.m0_wdata = 32'd0; bus.m1_wdata = 32'd0;
        bus.m0_wstrb = 4'd0;  bus.m1_wstrb = 4'd0;
        bus.s_ready  = 1'b0;  bus.s_rdata  = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        #1;
        checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid: got %b expected 0", bus.s_valid); end
        checks++; if ({bus.m0_ready, bus.m1_ready, bus.err} !== 3'b000) begin errors++; $display("FAIL rst_ready_err: got %b expected 000", {bus.m0_ready, bus.m1_ready, bus.err}); end
        checks++; if (bus.owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b expected 0", bus.owner); end
        checks++; if (bus.s_addr !== 32'd0) begin errors++; $display("FAIL rst_s_addr: got %h expected 0", bus.s_addr); end
        tick();
        reset = 1'b0;
        // stray slave completion while idle must be ignored
        tick();
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h0BAD_0BAD;
        #1;
        checks++; if ({bus.m0_ready, bus.m1_ready, bus.s_valid} !== 3'b000) begin errors++; $display("FAIL idle_s_ready: got %b expected 000", {bus.m0_ready, bus.m1_ready, bus.s_valid}); end
        tick();
        bus.s_ready = 1'b0;
    endtask

    task automatic test_single_write();
        tick();                                     // cycle N
        bus.m0_valid = 1'b1;
        bus.m0_addr  = 32'h1000_0000;
        bus.m0_wdata = 32'h1234_5678;
        bus.m0_wstrb = 4'hF;
        #1;
        checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL wr_s_valid_N: got %b expected 0", bus.s_valid); end
        tick();                                     // N+1
        checks++; if (bus.s_valid !== 1'b1) begin errors++; $display("FAIL wr_s_valid_N1: got %b expected 1", bus.s_valid); end
        checks++; if ({bus.s_addr, bus.s_wdata, bus.s_wstrb} !== {32'h1000_0000, 32'h1234_5678, 4'hF}) begin errors++; $display("FAIL wr_fwd: got %h %h %h expected 10000000 12345678 f", bus.s_addr, bus.s_wdata, bus.s_wstrb); end
        checks++; if ({bus.m0_ready, bus.owner} !== 2'b00) begin errors++; $display("FAIL wr_owner_N1: got ready/owner %b expected 00", {bus.m0_ready, bus.owner}); end
        tick();                                     // N+2
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'hAAAA_5555;
        #1;
        checks++; if ({bus.m0_ready, bus.m1_ready, bus.err, bus.s_valid} !== 4'b1001) begin errors++; $display("FAIL wr_ready_N2: got %b expected 1001", {bus.m0_ready, bus.m1_ready, bus.err, bus.s_valid}); end
        checks++; if ({bus.m0_rdata, bus.m1_rdata} !== {32'hAAAA_5555, 32'd0}) begin errors++; $display("FAIL wr_rdata_N2: got %h %h expected aaaa5555 0", bus.m0_rdata, bus.m1_rdata); end
        tick();                                     // N+3, DONE; new request arrives
        bus.s_ready  = 1'b0;
        bus.m0_addr  = 32'h0000_2000;
        bus.m0_wstrb = 4'h0;
        #1;
        checks++; if ({bus.s_valid, bus.m0_ready, bus.s_addr} !== {2'b00, 32'd0}) begin errors++; $display("FAIL done_quiet: got %b %b %h expected 0 0 0", bus.s_valid, bus.m0_ready, bus.s_addr); end
        tick();                                     // N+4, IDLE
        checks++; if (bus.s_valid !== 1'b0) begin errors++; $display("FAIL idle_N4: got %b expected 0", bus.s_valid); end
        tick();                                     // N+5, BUSY again
        checks++; if ({bus.s_valid, bus.s_addr, bus.s_wstrb} !== {1'b1, 32'h0000_2000, 4'h0}) begin errors++; $display("FAIL regrant_N5: got %b %h %h expected 1 00002000 0", bus.s_valid, bus.s_addr, bus.s_wstrb); end
        tick();
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'hCAFE_0001;
        #1;
        checks++; if ({bus.m0_ready, bus.m0_rdata} !== {1'b1, 32'hCAFE_0001}) begin errors++; $display("FAIL rd_ready: got %b %h expected 1 cafe0001", bus.m0_ready, bus.m0_rdata); end
        tick();
        bus.m0_valid = 1'b0;
        bus.s_ready  = 1'b0;
        tick();
    endtask

    // prio is 0 on entry: abort by m0 leaves it 0, so the next tie goes to m1
    task automatic test_abort();
        tick();
        bus.m0_valid = 1'b1;
        bus.m0_addr  = 32'h0000_0A00;
        tick(); tick(); tick();                     // BUSY 1..3
        checks++; if (bus.s_valid !== 1'b1) begin errors++; $display("FAIL abort_busy3: got %b expected 1", bus.s_valid); end
        tick();
        bus.m0_valid = 1'b0;
        #1;
        checks++; if ({bus.m0_ready, bus.err, bus.s_valid} !== 3'b000) begin errors++; $display("FAIL abort_drop: got %b expected 000", {bus.m0_ready, bus.err, bus.s_valid}); end
        tick();                                     // IDLE, tie
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0AAA;
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0BBB;
        tick();
        checks++; if ({bus.owner, bus.s_addr} !== {1'b1, 32'h0000_0BBB}) begin errors++; $display("FAIL abort_tie: got %b %h expected 1 00000bbb", bus.owner, bus.s_addr); end
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h1111_2222;
        #1;
        checks++; if ({bus.m1_ready, bus.m0_ready, bus.m1_rdata, bus.m0_rdata} !== {2'b10, 32'h1111_2222, 32'd0}) begin errors++; $display("FAIL tie_m1_done: got %b %b %h %h expected 1 0 11112222 0", bus.m1_ready, bus.m0_ready, bus.m1_rdata, bus.m0_rdata); end
        tick();                                     // DONE
        bus.m1_valid = 1'b0;
        bus.s_ready  = 1'b0;
        tick(); tick();                             // IDLE then BUSY for m0
        checks++; if ({bus.owner, bus.s_addr} !== {1'b0, 32'h0000_0AAA}) begin errors++; $display("FAIL tie_m0_next: got %b %h expected 0 00000aaa", bus.owner, bus.s_addr); end
        bus.s_ready = 1'b1;
        #1;
        checks++; if (bus.m0_ready !== 1'b1) begin errors++; $display("FAIL tie_m0_done: got %b expected 1", bus.m0_ready); end
        tick();
        bus.m0_valid = 1'b0;
        bus.s_ready  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        tick();
        bus.m1_valid = 1'b1;
        bus.m1_addr  = 32'h0000_0C00;
        bus.m1_wstrb = 4'h0;
        bus.s_rdata  = 32'h5555_5555;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (bus.m1_ready || bus.err || !bus.s_valid) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d bad cycles expected 0", early); end
        tick();                                     // 16th BUSY cycle
        checks++; if ({bus.m1_ready, bus.err, bus.m0_ready} !== 3'b110) begin errors++; $display("FAIL to_pulse: got %b expected 110", {bus.m1_ready, bus.err, bus.m0_ready}); end
        checks++; if (bus.m1_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata: got %h expected deadbeef", bus.m1_rdata); end
        tick();
        bus.m1_valid = 1'b0;
        #1;
        checks++; if ({bus.s_valid, bus.err, bus.m1_ready} !== 3'b000) begin errors++; $display("FAIL to_after: got %b expected 000", {bus.s_valid, bus.err, bus.m1_ready}); end
        tick();
    endtask

    task automatic test_timeout_race();
        tick();
        bus.m0_valid = 1'b1;
        bus.m0_addr  = 32'h0000_0D00;
        for (int c = 1; c <= 15; c++) tick();
        tick();                                     // 16th BUSY cycle
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h0BAD_F00D;
        #1;
        checks++; if ({bus.m0_ready, bus.err} !== 2'b10) begin errors++; $display("FAIL race_ready_err: got %b expected 10", {bus.m0_ready, bus.err}); end
        checks++; if (bus.m0_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL race_rdata: got %h expected 0badf00d", bus.m0_rdata); end
        tick();
        bus.m0_valid = 1'b0;
        bus.s_ready  = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        tick();
        bus.m0_valid = 1'b1;
        bus.m0_addr  = 32'h0000_0E00;
        tick();
        checks++; if ({bus.s_valid, bus.owner} !== 2'b10) begin errors++; $display("FAIL rb_busy: got %b expected 10", {bus.s_valid, bus.owner}); end
        bus.m1_valid = 1'b1;
        bus.m1_addr  = 32'h0000_0F00;
        #1;
        reset = 1'b1;
        #1;
        checks++; if ({bus.s_valid, bus.m0_ready, bus.err} !== 3'b000) begin errors++; $display("FAIL rb_async: got %b expected 000", {bus.s_valid, bus.m0_ready, bus.err}); end
        tick();
        bus.m0_valid = 1'b0;
        bus.s_ready  = 1'b1;
        bus.s_rdata  = 32'h7777_8888;
        reset = 1'b0;
        #1;
        checks++; if ({bus.m0_ready, bus.m1_ready, bus.err} !== 3'b000) begin errors++; $display("FAIL rb_release: got %b expected 000", {bus.m0_ready, bus.m1_ready, bus.err}); end
        tick();
        checks++; if ({bus.owner, bus.m1_ready, bus.m0_ready, bus.m1_rdata} !== {3'b110, 32'h7777_8888}) begin errors++; $display("FAIL rb_m1_first: got %b %b %b %h expected 1 1 0 77778888", bus.owner, bus.m1_ready, bus.m0_ready, bus.m1_rdata); end
        tick();
        bus.m1_valid = 1'b0;
        bus.s_ready  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int done_n;
        int n0;
        int n1;
        int bad;
        done_n = 0; n0 = 0; n1 = 0; bad = 0;
        #1;
        reset = 1'b1;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h0000_0100;
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h0000_0200;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 30 && done_n < 4; c++) begin
            tick();
            bus.s_ready = 1'b0;
            #1;
            if (bus.s_valid) begin
                bus.s_ready = 1'b1;
                bus.s_rdata = 32'h5000_0000 + 32'(c);
            end
            #1;
            if (bus.m0_ready) n0++;
            if (bus.m1_ready) n1++;
            if (bus.s_ready) begin
                if (bus.owner !== 1'(done_n % 2)) bad++;
                if (bus.owner ? (bus.m1_ready !== 1'b1 || bus.m0_ready !== 1'b0 || bus.m1_rdata !== bus.s_rdata)
                              : (bus.m0_ready !== 1'b1 || bus.m1_ready !== 1'b0 || bus.m0_rdata !== bus.s_rdata)) bad++;
                done_n++;
            end
        end
        checks++; if (done_n !== 4) begin errors++; $display("FAIL b2b_count: got %0d transactions expected 4", done_n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_order: got %0d bad grants expected 0 (order 0,1,0,1)", bad); end
        checks++; if ({n0, n1} !== {32'd2, 32'd2}) begin errors++; $display("FAIL b2b_pulses: got m0=%0d m1=%0d expected 2 2", n0, n1); end
        bus.m0_valid = 1'b0;
        bus.m1_valid = 1'b0;
        bus.s_ready  = 1'b0;
        tick(); tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_write();
        test_abort();
        test_timeout();
        test_timeout_race();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
